clk_health_monitor: RTL and testbench
=====================================

// Module: clk_health_monitor
// PURPOSE
//  Frequency/presence monitor for one redundant DDR5 RCD clock (mon_clk), measured against active_clk.
//  Counts mon_clk edges per fixed window and qualifies the count with hysteresis in an FSM.
//  Produces the good/fail status and a req/ack failover request consumed by the clock failover controller.
// PARAMETERS
//  CNT_W      16    width of edge counter and last_count
//  WIN_CYCLES 1024  active_clk cycles per measurement window (>=4)
//  EXP_MIN    480   min mon_clk rising edges per window for a good window (inclusive)
//  EXP_MAX    544   max mon_clk rising edges per window for a good window (inclusive)
//  GOOD_WINS  4     consecutive good windows needed to enter GOOD (>=1)
//  BAD_WINS   2     consecutive bad windows needed to enter FAIL (>=1)
// PORTS
//  active_clk  in   1      reference/system clock
//  rst_n       in   1      reset, asynchronous, active-low (both domains)
//  mon_clk     in   1      monitored clock
//  enable      in   1      monitor enable (active_clk domain)
//  fail_ack    in   1      failover controller acknowledge
//  fail_req    out  1      failover request (level, handshake)
//  mon_good    out  1      monitored clock qualified good
//  mon_fail    out  1      monitored clock declared failed
//  win_done    out  1      1-cycle pulse: window closed, last_count updated
//  last_count  out  CNT_W  edge count of last closed window
//  state       out  3      FSM state: IDLE=0 CHECK=1 GOOD=2 SUSPECT=3 FAIL=4
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE; counters, sync flops, mon_tog 0.
//  - mon_clk domain: mon_tog toggles each mon_clk posedge; no other logic in that domain.
//  - Sync: mon_tog -> s1 -> s2 -> s3 in active_clk; edge = s2^s3; one edge = one mon_clk posedge.
//  - win_cnt increments on edge, saturates at 2^CNT_W-1; win_tmr counts 0..WIN_CYCLES-1, wraps.
//  - Window close (win_tmr==WIN_CYCLES-1): last_count <= win_cnt + edge (terminal-cycle edge counts,
//    saturating); win_cnt <= 0; win_done pulses the following cycle, coincident with new last_count.
//  - good window: EXP_MIN <= count <= EXP_MAX; else bad. FSM evaluates at window close only.
//  - gc/bc = consecutive good/bad window counters; either kind of window clears the other's counter.
//  - IDLE: enable=1 -> CHECK (timer and win_cnt start from 0 next cycle).
//  - CHECK: gc reaches GOOD_WINS -> GOOD; bc reaches BAD_WINS -> FAIL.
//  - GOOD: bad window -> SUSPECT (or FAIL directly if BAD_WINS==1).
//  - SUSPECT: good window -> GOOD; bc reaches BAD_WINS -> FAIL.
//  - FAIL: gc reaches GOOD_WINS -> GOOD (recovery).
//  - enable=0 in any state -> IDLE next cycle; win_tmr, win_cnt, gc, bc cleared; last_count holds.
//  - mon_good = state in {GOOD,SUSPECT}; mon_fail = (state==FAIL); both registered, no extra latency.
//  - Handshake:
//    - fail_req rises the cycle after entering FAIL, only if fail_ack==0; otherwise it waits for ack low.
//    - Held high until fail_ack==1 is sampled, then falls next cycle.
//    - One request per FAIL entry; re-entering FAIL after recovery issues a new request.
//    - A pending request is kept through enable=0 or FAIL exit until acked (no abandoned handshake).
//    - fail_ack while fail_req=0: ignored.
//  - Async reset mid-window or mid-handshake: immediate return to reset values; no request is replayed.
// CONFIGURATION
//  CLK_HM_STICKY_ERR_EN defined:
//    - Adds ports err_clr (in, 1) and err_sticky (out, 1).
//    - err_sticky sets on any FAIL entry and on any count saturation.
//    - Cleared by err_clr=1 (clear wins over set in the same cycle); reset 0.
//  Not defined: both ports and logic absent; behaviour otherwise identical.
// TESTING (WIN_CYCLES=100, EXP_MIN=45, EXP_MAX=55, GOOD_WINS=3, BAD_WINS=2)
//  1. enable=1, mon_clk = active_clk/2:
//     last_count=50 (+/-1) per window; mon_good=1, state=2 after 3rd win_done.
//  2. From GOOD, stop mon_clk:
//     - 1st bad window -> state=3.
//     - 2nd bad window -> state=4, mon_fail=1, fail_req=1 next cycle.
//     - Hold fail_ack=0 for 20 cycles: fail_req stays 1. Assert fail_ack: fail_req=0 next cycle.
//  3. mon_clk = active_clk*2/3 (~66 edges):
//     never GOOD; FAIL after 2 windows; restore /2 clock -> GOOD after 3 good windows.
//  4. Alternating good/bad windows from CHECK: never reaches GOOD or FAIL; gc/bc cleared each window.
//  5. Reset asserted at win_tmr=50 in SUSPECT with fail_req pending:
//     all outputs 0, state=0; after release and enable=1, clean CHECK.
//  6. enable=0 while fail_req=1: state=0 next cycle, fail_req held until fail_ack=1.
//     With CLK_HM_STICKY_ERR_EN: err_sticky=1 until err_clr pulse.

Source files
------------

// File: rtl/clk_health_monitor.sv
// clk_health_monitor: windowed edge-count frequency/presence monitor with hysteresis FSM.
// Define CLK_HM_STICKY_ERR_EN to add the err_clr/err_sticky sticky error flag.
module clk_health_monitor #(
    parameter int CNT_W      = 16,
    parameter int WIN_CYCLES = 1024,
    parameter int EXP_MIN    = 480,
    parameter int EXP_MAX    = 544,
    parameter int GOOD_WINS  = 4,
    parameter int BAD_WINS   = 2
) (
    input  logic             active_clk,
    input  logic             rst_n,
    input  logic             mon_clk,
    input  logic             enable,
    input  logic             fail_ack,
`ifdef CLK_HM_STICKY_ERR_EN
    input  logic             err_clr,
    output logic             err_sticky,
`endif
    output logic             fail_req,
    output logic             mon_good,
    output logic             mon_fail,
    output logic             win_done,
    output logic [CNT_W-1:0] last_count,
    output logic [2:0]       state
);

    localparam int TMR_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    localparam int GC_W  = $clog2(GOOD_WINS + 1);
    localparam int BC_W  = $clog2(BAD_WINS + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        GOOD    = 3'd2,
        SUSPECT = 3'd3,
        FAIL    = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  last_q, last_d;
    logic [GC_W-1:0]   gc_q, gc_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    logic              done_q;
    logic              good_q, fail_q;
    logic              req_q, req_d;
    logic              pend_q, pend_d;
    logic              tog_q;
    logic              s1_q, s2_q, s3_q;

    logic              mon_edge;
    logic              run;
    logic              close;
    logic              win_good;
    logic              sat_hit;
    logic              entry;
    logic              launch;
    logic [CNT_W-1:0]  cnt_inc;
    logic [GC_W-1:0]   gc_inc;
    logic [BC_W-1:0]   bc_inc;
    logic              gc_hit;
    logic              bc_hit;

    // Only logic in the monitored domain: a toggle carried across by level.
    always_ff @(posedge mon_clk or negedge rst_n) begin
        if (!rst_n) begin
            tog_q <= 1'b0;
        end else begin
            tog_q <= ~tog_q;
        end
    end

    always_ff @(posedge active_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= tog_q;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign mon_edge = s2_q ^ s3_q;
    assign run      = enable && (state_q != IDLE);
    assign close    = run && (tmr_q == TMR_W'(WIN_CYCLES - 1));
    assign sat_hit  = run && mon_edge && (cnt_q == {CNT_W{1'b1}});
    assign cnt_inc  = (mon_edge && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

    assign win_good = (cnt_inc >= CNT_W'(EXP_MIN)) && (cnt_inc <= CNT_W'(EXP_MAX));

    assign gc_inc = (gc_q == GC_W'(GOOD_WINS)) ? gc_q : gc_q + 1'b1;
    assign bc_inc = (bc_q == BC_W'(BAD_WINS)) ? bc_q : bc_q + 1'b1;
    assign gc_hit = (gc_inc == GC_W'(GOOD_WINS));
    assign bc_hit = (bc_inc == BC_W'(BAD_WINS));

    always_comb begin
        tmr_d  = tmr_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        gc_d   = gc_q;
        bc_d   = bc_q;
        if (!run) begin
            tmr_d = '0;
            cnt_d = '0;
            gc_d  = '0;
            bc_d  = '0;
        end else if (close) begin
            tmr_d  = '0;
            cnt_d  = '0;
            last_d = cnt_inc;
            if (win_good) begin
                gc_d = gc_inc;
                bc_d = '0;
            end else begin
                gc_d = '0;
                bc_d = bc_inc;
            end
        end else begin
            tmr_d = tmr_q + 1'b1;
            cnt_d = cnt_inc;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = CHECK;
                CHECK: begin
                    if (close && win_good && gc_hit) begin
                        state_d = GOOD;
                    end else if (close && !win_good && bc_hit) begin
                        state_d = FAIL;
                    end
                end
                GOOD: begin
                    if (close && !win_good) begin
                        state_d = bc_hit ? FAIL : SUSPECT;
                    end
                end
                SUSPECT: begin
                    if (close && win_good) begin
                        state_d = GOOD;
                    end else if (close && bc_hit) begin
                        state_d = FAIL;
                    end
                end
                FAIL: begin
                    if (close && win_good && gc_hit) begin
                        state_d = GOOD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A request is armed per FAIL entry and survives disable/exit until acked.
    assign entry  = (state_d == FAIL) && (state_q != FAIL);
    assign launch = pend_q && !req_q && !fail_ack;
    assign req_d  = req_q ? !fail_ack : launch;
    assign pend_d = entry || (pend_q && !launch);

    always_ff @(posedge active_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            gc_q    <= '0;
            bc_q    <= '0;
            done_q  <= 1'b0;
            good_q  <= 1'b0;
            fail_q  <= 1'b0;
            req_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gc_q    <= gc_d;
            bc_q    <= bc_d;
            done_q  <= close;
            good_q  <= (state_d == GOOD) || (state_d == SUSPECT);
            fail_q  <= (state_d == FAIL);
            req_q   <= req_d;
            pend_q  <= pend_d;
        end
    end

`ifdef CLK_HM_STICKY_ERR_EN
    logic err_q, err_d;

    assign err_d = err_clr ? 1'b0 : (err_q || entry || sat_hit);

    always_ff @(posedge active_clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_sticky = err_q;
`endif

    assign fail_req   = req_q;
    assign mon_good   = good_q;
    assign mon_fail   = fail_q;
    assign win_done   = done_q;
    assign last_count = last_q;
    assign state      = state_q;

endmodule

// File: tb/tb_clk_health_monitor.sv
// tb_clk_health_monitor: directed scoreboard bench for clk_health_monitor.
// Window expectations are queued at stimulus time and popped on each win_done.
module tb_clk_health_monitor;

    localparam int CNT_W = 16;
    localparam int WIN   = 100;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_GOOD    = 3'd2;
    localparam logic [2:0] S_SUSPECT = 3'd3;
    localparam logic [2:0] S_FAIL    = 3'd4;

    typedef struct {
        logic [2:0] st;
        int         lo;
        int         hi;
    } exp_t;

    logic             active_clk;
    logic             rst_n;
    logic             mon_clk;
    logic             enable;
    logic             fail_ack;
    logic             fail_req;
    logic             mon_good;
    logic             mon_fail;
    logic             win_done;
    logic [CNT_W-1:0] last_count;
    logic [2:0]       state;
`ifdef CLK_HM_STICKY_ERR_EN
    logic             err_clr;
    logic             err_sticky;
`endif

    int   errors;
    int   checks;
    int   mode;
    exp_t sb[$];

    clk_health_monitor #(
        .CNT_W(CNT_W),
        .WIN_CYCLES(WIN),
        .EXP_MIN(45),
        .EXP_MAX(55),
        .GOOD_WINS(3),
        .BAD_WINS(2)
    ) dut (
        .active_clk(active_clk),
        .rst_n(rst_n),
        .mon_clk(mon_clk),
        .enable(enable),
        .fail_ack(fail_ack),
`ifdef CLK_HM_STICKY_ERR_EN
        .err_clr(err_clr),
        .err_sticky(err_sticky),
`endif
        .fail_req(fail_req),
        .mon_good(mon_good),
        .mon_fail(mon_fail),
        .win_done(win_done),
        .last_count(last_count),
        .state(state)
    );

    initial begin
        active_clk = 1'b0;
        forever #5 active_clk = ~active_clk;
    end

    // mode 0: stopped, 1: period 20 (half rate), 2: period 15 (2/3 rate)
    initial begin
        mon_clk = 1'b0;
        #3;
        forever begin
            if (mode == 1) begin
                #10 mon_clk = ~mon_clk;
            end else if (mode == 2) begin
                #7 mon_clk = 1'b1;
                #8 mon_clk = 1'b0;
            end else begin
                mon_clk = 1'b0;
                #1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
        checks++;
        assert (!$isunknown(obs) && int'(obs) >= lo && int'(obs) <= hi) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge active_clk);
        #1;
    endtask

    task automatic run_win(input string tag, input logic [2:0] st, input int lo, input int hi);
        exp_t e;
        int   n;
        e.st = st;
        e.lo = lo;
        e.hi = hi;
        sb.push_back(e);
        n = 0;
        do begin
            tick();
            n++;
        end while (win_done !== 1'b1 && n < 3 * WIN);
        chk({tag, "_win_done"}, 32'(win_done), 32'd1);
        e = sb.pop_front();
        chk({tag, "_state"}, 32'(state), 32'(e.st));
        chk_rng({tag, "_count"}, 32'(last_count), e.lo, e.hi);
        chk({tag, "_good"}, 32'(mon_good), 32'((e.st == S_GOOD) || (e.st == S_SUSPECT)));
        chk({tag, "_fail"}, 32'(mon_fail), 32'(e.st == S_FAIL));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_good"}, 32'(mon_good), 32'd0);
        chk({tag, "_fail"}, 32'(mon_fail), 32'd0);
        chk({tag, "_req"}, 32'(fail_req), 32'd0);
        chk({tag, "_done"}, 32'(win_done), 32'd0);
        chk({tag, "_cnt"}, 32'(last_count), 32'd0);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        mode     = 1;
        rst_n    = 1'b0;
        enable   = 1'b0;
        fail_ack = 1'b0;
`ifdef CLK_HM_STICKY_ERR_EN
        err_clr  = 1'b0;
`endif
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_hold", 32'(state), 32'(S_IDLE));

        // 1. half-rate clock qualifies after three good windows
        enable = 1'b1;
        run_win("t1_w1", S_CHECK, 49, 51);
        run_win("t1_w2", S_CHECK, 49, 51);
        run_win("t1_w3", S_GOOD, 49, 51);
        tick();
        chk("t1_done_pulse", 32'(win_done), 32'd0);

        // 2. stopped clock: SUSPECT then FAIL with handshake
        mode = 0;
        run_win("t2_w1", S_SUSPECT, 0, 3);
        run_win("t2_w2", S_FAIL, 0, 3);
        chk("t2_req_entry", 32'(fail_req), 32'd0);
        tick();
        chk("t2_req_rise", 32'(fail_req), 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t2_req_hold", 32'(fail_req), 32'd1);
        end
        fail_ack = 1'b1;
        tick();
        chk("t2_req_fall", 32'(fail_req), 32'd0);
        fail_ack = 1'b0;
        run_win("t2_w3", S_FAIL, 0, 0);
        chk("t2_no_rerequest", 32'(fail_req), 32'd0);

        // 3. fast clock never qualifies; recovery on half-rate
        enable = 1'b0;
        tick();
        chk("t3_idle", 32'(state), 32'(S_IDLE));
        chk("t3_fail_clr", 32'(mon_fail), 32'd0);
        mode   = 2;
        enable = 1'b1;
        run_win("t3_w1", S_CHECK, 64, 68);
        run_win("t3_w2", S_FAIL, 64, 68);
        tick();
        chk("t3_req_rise", 32'(fail_req), 32'd1);
        fail_ack = 1'b1;
        tick();
        chk("t3_req_fall", 32'(fail_req), 32'd0);
        fail_ack = 1'b0;
        mode = 1;
        run_win("t3_w3", S_FAIL, 46, 54);
        run_win("t3_w4", S_FAIL, 49, 51);
        run_win("t3_w5", S_GOOD, 49, 51);

        // 4. alternating windows from CHECK never resolve
        enable = 1'b0;
        tick();
        chk("t4_idle", 32'(state), 32'(S_IDLE));
        enable = 1'b1;
        run_win("t4_w1", S_CHECK, 49, 51);
        mode = 0;
        run_win("t4_w2", S_CHECK, 0, 3);
        mode = 1;
        run_win("t4_w3", S_CHECK, 46, 52);
        mode = 0;
        run_win("t4_w4", S_CHECK, 0, 3);

        // 5. FAIL unacked, recover, SUSPECT, then reset mid-window
        run_win("t5_w1", S_FAIL, 0, 0);
        tick();
        chk("t5_req_rise", 32'(fail_req), 32'd1);
        mode = 1;
        run_win("t5_w2", S_FAIL, 46, 52);
        run_win("t5_w3", S_FAIL, 49, 51);
        run_win("t5_w4", S_GOOD, 49, 51);
        chk("t5_req_kept", 32'(fail_req), 32'd1);
        mode = 0;
        run_win("t5_w5", S_SUSPECT, 0, 3);
        chk("t5_req_suspect", 32'(fail_req), 32'd1);
        repeat (50) @(posedge active_clk);
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("t5_rst");
        mode = 1;
        repeat (3) tick();
        rst_n = 1'b1;
        run_win("t5_w6", S_CHECK, 46, 52);
        chk("t5_no_replay", 32'(fail_req), 32'd0);

        // 6. disable with a pending request
        mode = 0;
        run_win("t6_w1", S_CHECK, 0, 3);
        run_win("t6_w2", S_FAIL, 0, 0);
        tick();
        chk("t6_req_rise", 32'(fail_req), 32'd1);
        enable = 1'b0;
        tick();
        chk("t6_idle", 32'(state), 32'(S_IDLE));
        chk("t6_req_held", 32'(fail_req), 32'd1);
        repeat (10) tick();
        chk("t6_req_held2", 32'(fail_req), 32'd1);
        fail_ack = 1'b1;
        tick();
        chk("t6_req_fall", 32'(fail_req), 32'd0);
        fail_ack = 1'b0;
`ifdef CLK_HM_STICKY_ERR_EN
        chk("t6_sticky_set", 32'(err_sticky), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t6_sticky_clr", 32'(err_sticky), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
